// File: rtl/adc_sample_averager_if.sv
// Sample-side and result-side signals of the ADC averager, grouped for port use.
// The averager takes the slave view; whoever drives raw samples takes the master view.
interface adc_sample_averager_if #(
  parameter int DATA_W   = 8,
  parameter int CH_W     = 2,
  parameter int AVG_LOG2 = 2
);
  logic [CH_W-1:0]     ch_sel;
  logic [DATA_W-1:0]   raw_data;
  logic                raw_valid;
  logic [DATA_W-1:0]   avg_data;
  logic                avg_valid;
  logic [CH_W-1:0]     avg_channel;
  logic                busy;
  logic                timeout;
  logic [AVG_LOG2:0]   sample_count;

  modport master (
    output ch_sel, raw_data, raw_valid,
    input  avg_data, avg_valid, avg_channel, busy, timeout, sample_count
  );

  modport slave (
    input  ch_sel, raw_data, raw_valid,
    output avg_data, avg_valid, avg_channel, busy, timeout, sample_count
  );
endinterface

// File: rtl/adc_sample_averager.sv
// Averages 2^AVG_LOG2 consecutive samples of one channel into a rounded mean;
// a channel change or an over-long gap between samples drops the partial batch.
module adc_sample_averager #(
  parameter int DATA_W         = 8,
  parameter int CH_W           = 2,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  adc_sample_averager_if.slave bus
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(2 ** AVG_LOG2);
  localparam logic [ACC_W-1:0] HALF    = ACC_W'((2 ** AVG_LOG2) / 2);
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT_CYCLES);
  localparam bit               SINGLE  = (AVG_LOG2 == 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic [DATA_W-1:0] avg_data_q, avg_data_d;
  logic [CH_W-1:0]   avg_chan_q, avg_chan_d;
  logic              timeout_q, timeout_d;
  logic              load_avg;

  // Round half up; with AVG_LOG2=0 HALF is zero and the shift is a no-op.
  function automatic logic [DATA_W-1:0] round_mean(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] sum;
    sum = acc + HALF;
    return DATA_W'(sum >> AVG_LOG2);
  endfunction

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    avg_data_d = avg_data_q;
    avg_chan_d = avg_chan_q;
    timeout_d  = 1'b0;
    load_avg   = 1'b0;

    unique case (state_q)
      IDLE, EMIT: begin
        if (bus.raw_valid) begin
          chan_d  = bus.ch_sel;
          acc_d   = ACC_W'(bus.raw_data);
          cnt_d   = CNT_W'(1);
          idle_d  = '0;
          if (SINGLE) begin
            state_d  = EMIT;
            load_avg = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end
      end

      ACCUM: begin
        // Channel change outranks both a same-cycle sample and a timeout.
        if (bus.ch_sel != chan_q) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end else if (bus.raw_valid) begin
          acc_d  = acc_q + ACC_W'(bus.raw_data);
          cnt_d  = cnt_q + CNT_W'(1);
          idle_d = '0;
          if (cnt_d == N_CNT) begin
            state_d  = EMIT;
            load_avg = 1'b1;
          end
        end else begin
          idle_d = idle_q + TO_W'(1);
          if (idle_d == TO_LIM) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        idle_d  = '0;
      end
    endcase

    if (load_avg) begin
      avg_data_d = round_mean(acc_d);
      avg_chan_d = chan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      chan_q     <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      avg_data_q <= '0;
      avg_chan_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      avg_data_q <= avg_data_d;
      avg_chan_q <= avg_chan_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.avg_data     = avg_data_q;
  assign bus.avg_valid    = (state_q == EMIT);
  assign bus.avg_channel  = avg_chan_q;
  assign bus.busy         = (state_q == ACCUM);
  assign bus.timeout      = timeout_q;
  assign bus.sample_count = cnt_q;
endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: batches of four, rounding, channel
// change, timeout, streaming and mid-batch reset, each with hand-computed results.
module tb_adc_sample_averager;
  localparam int DATA_W   = 8;
  localparam int CH_W     = 2;
  localparam int AVG_LOG2 = 2;
  localparam int TO_CYC   = 16;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  adc_sample_averager_if #(.DATA_W(DATA_W), .CH_W(CH_W), .AVG_LOG2(AVG_LOG2)) bus ();

  adc_sample_averager #(
    .DATA_W(DATA_W), .CH_W(CH_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
    bus.ch_sel    = ch;
    bus.raw_data  = d;
    bus.raw_valid = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.raw_valid = 1'b0;
    bus.raw_data  = '0;
    bus.ch_sel    = '0;
    step();
    step();
    total += 6;
    if (bus.avg_data !== 8'd0) begin bad++; $display("FAIL reset_avg_data got=%0d want=0", bus.avg_data); end
    if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL reset_avg_valid got=%b want=0", bus.avg_valid); end
    if (bus.avg_channel !== 2'd0) begin bad++; $display("FAIL reset_avg_channel got=%0d want=0", bus.avg_channel); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", bus.timeout); end
    if (bus.sample_count !== 3'd0) begin bad++; $display("FAIL reset_sample_count got=%0d want=0", bus.sample_count); end
    reset = 1'b0;
    step();
    $display("reset: outputs checked");
  endtask

  // Four samples on one channel, then check the emitted mean and the pulse width.
  task automatic run_batch(input string name, input logic [CH_W-1:0] ch,
                           input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                           input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3,
                           input logic [DATA_W-1:0] exp);
    send(ch, d0);
    send(ch, d1);
    send(ch, d2);
    total += 2;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b want=1", name, bus.busy); end
    if (bus.sample_count !== 3'd3) begin bad++; $display("FAIL %s_count3 got=%0d want=3", name, bus.sample_count); end
    send(ch, d3);
    bus.raw_valid = 1'b0;
    total += 6;
    if (bus.avg_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", name, bus.avg_valid); end
    if (bus.avg_data !== exp) begin bad++; $display("FAIL %s_data got=%0d want=%0d", name, bus.avg_data, exp); end
    if (bus.avg_channel !== ch) begin bad++; $display("FAIL %s_channel got=%0d want=%0d", name, bus.avg_channel, ch); end
    if (bus.sample_count !== 3'd4) begin bad++; $display("FAIL %s_count4 got=%0d want=4", name, bus.sample_count); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_busy_emit got=%b want=0", name, bus.busy); end
    if (bus.timeout !== 1'b0) begin bad++; $display("FAIL %s_timeout got=%b want=0", name, bus.timeout); end
    step();
    total += 3;
    if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL %s_pulse got=%b want=0", name, bus.avg_valid); end
    if (bus.avg_data !== exp) begin bad++; $display("FAIL %s_hold got=%0d want=%0d", name, bus.avg_data, exp); end
    if (bus.sample_count !== 3'd0) begin bad++; $display("FAIL %s_count0 got=%0d want=0", name, bus.sample_count); end
    $display("%s: ch=%0d samples %0d,%0d,%0d,%0d avg=%0d", name, ch, d0, d1, d2, d3, bus.avg_data);
  endtask

  task automatic test_basic();
    run_batch("basic", 2'd1, 8'd10, 8'd20, 8'd30, 8'd41, 8'd25);
  endtask

  task automatic test_rounding();
    run_batch("round_1222", 2'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2);
    run_batch("round_max", 2'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    run_batch("round_half", 2'd3, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1);
  endtask

  task automatic test_channel_change();
    send(2'd0, 8'd5);
    send(2'd0, 8'd5);
    total += 1;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL chg_busy_before got=%b want=1", bus.busy); end
    send(2'd2, 8'd200);
    bus.raw_valid = 1'b0;
    total += 3;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL chg_busy_after got=%b want=0", bus.busy); end
    if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL chg_valid got=%b want=0", bus.avg_valid); end
    if (bus.sample_count !== 3'd0) begin bad++; $display("FAIL chg_count got=%0d want=0", bus.sample_count); end
    step();
    total += 2;
    if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL chg_valid2 got=%b want=0", bus.avg_valid); end
    if (bus.timeout !== 1'b0) begin bad++; $display("FAIL chg_timeout got=%b want=0", bus.timeout); end
    $display("channel_change: batch on ch0 dropped");
    run_batch("chg_new", 2'd2, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8);
  endtask

  task automatic test_timeout();
    send(2'd3, 8'd1);
    send(2'd3, 8'd2);
    send(2'd3, 8'd3);
    bus.raw_valid = 1'b0;
    for (int i = 1; i <= TO_CYC; i++) begin
      total += 2;
      if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_early idle=%0d got=%b want=0", i, bus.timeout); end
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL to_busy idle=%0d got=%b want=1", i, bus.busy); end
      step();
    end
    total += 4;
    if (bus.timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", bus.timeout); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_busy_end got=%b want=0", bus.busy); end
    if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL to_valid got=%b want=0", bus.avg_valid); end
    if (bus.sample_count !== 3'd0) begin bad++; $display("FAIL to_count got=%0d want=0", bus.sample_count); end
    step();
    total += 1;
    if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_width got=%b want=0", bus.timeout); end
    $display("timeout: pulse after %0d idle cycles", TO_CYC);
    run_batch("to_next", 2'd3, 8'd6, 8'd6, 8'd6, 8'd7, 8'd6);
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] dat [12];
    logic [DATA_W-1:0] exp;
    dat = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd8, 8'd8, 8'd8, 8'd8, 8'd12, 8'd12, 8'd12, 8'd12};
    for (int i = 0; i < 12; i++) begin
      send(2'd1, dat[i]);
      total += 2;
      if (bus.avg_valid !== ((i % 4) == 3)) begin
        bad++; $display("FAIL stream_valid i=%0d got=%b want=%b", i, bus.avg_valid, ((i % 4) == 3));
      end
      if (bus.sample_count !== 3'((i % 4) + 1)) begin
        bad++; $display("FAIL stream_count i=%0d got=%0d want=%0d", i, bus.sample_count, (i % 4) + 1);
      end
      if ((i % 4) == 3) begin
        exp = dat[i];
        total += 1;
        if (bus.avg_data !== exp) begin bad++; $display("FAIL stream_data i=%0d got=%0d want=%0d", i, bus.avg_data, exp); end
        $display("stream: batch %0d avg=%0d", i / 4, bus.avg_data);
      end
    end
    bus.raw_valid = 1'b0;
    step();
    total += 1;
    if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL stream_tail got=%b want=0", bus.avg_valid); end
  endtask

  task automatic test_reset_mid_batch();
    send(2'd2, 8'd50);
    send(2'd2, 8'd60);
    bus.raw_valid = 1'b0;
    reset         = 1'b1;
    step();
    total += 6;
    if (bus.avg_data !== 8'd0) begin bad++; $display("FAIL mid_avg_data got=%0d want=0", bus.avg_data); end
    if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL mid_avg_valid got=%b want=0", bus.avg_valid); end
    if (bus.avg_channel !== 2'd0) begin bad++; $display("FAIL mid_avg_channel got=%0d want=0", bus.avg_channel); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
    if (bus.timeout !== 1'b0) begin bad++; $display("FAIL mid_timeout got=%b want=0", bus.timeout); end
    if (bus.sample_count !== 3'd0) begin bad++; $display("FAIL mid_sample_count got=%0d want=0", bus.sample_count); end
    reset = 1'b0;
    $display("reset_mid_batch: outputs cleared");
    run_batch("mid_next", 2'd2, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_channel_change();
    test_timeout();
    test_back_to_back();
    test_reset_mid_batch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
